prog_counter: RTL

//   Parametrised programmable counter; successor to the fixed 4-bit counter behind tt_um_counter.

---
 rtl/prog_counter_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/prog_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types and defaults for the programmable counter.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned PW_DEF    = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: one tick every presc+1 enabled cycles, restartable.
module tick_prescaler
  import prog_counter_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [PW-1:0] presc,
  input  logic          restart,
  output logic          tick
);

  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == presc);

  // >= so that lowering presc below the running count returns to 0 promptly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt >= presc) pcnt <= '0;
      else               pcnt <= pcnt + ONE;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down/bounce/hold counter with prescaler, load, modulo,
// terminal-count pulse and sticky wrap flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned PW    = PW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulo,
  input  logic [PW-1:0]    presc,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             wrap_sticky
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic tick;

  tick_prescaler #(.PW(PW)) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .presc   (presc),
    .restart (load),
    .tick    (tick)
  );

  // wrap_sticky is cleared first and re-set in each wrap branch, so a
  // coincident wrap overrides clr_wrap through the later assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      dir         <= 1'b1;
      tc          <= 1'b0;
      wrap_sticky <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_wrap) wrap_sticky <= 1'b0;

      if (load) begin
        count <= (load_val > modulo) ? modulo : load_val;
      end else if (tick) begin
        case (mode_e'(mode))
          MODE_UP: begin
            dir <= 1'b1;
            if (count >= modulo) begin
              count       <= '0;
              tc          <= 1'b1;
              wrap_sticky <= 1'b1;
            end else begin
              count <= count + ONE;
            end
          end
          MODE_DOWN: begin
            dir <= 1'b0;
            if (count == '0) begin
              count       <= modulo;
              tc          <= 1'b1;
              wrap_sticky <= 1'b1;
            end else if (count > modulo) begin
              count <= modulo;
            end else begin
              count <= count - ONE;
            end
          end
          MODE_BOUNCE: begin
            if (modulo == '0) begin
              count       <= '0;
              dir         <= ~dir;
              tc          <= 1'b1;
              wrap_sticky <= 1'b1;
            end else if (dir && (count >= modulo)) begin
              dir         <= 1'b0;
              count       <= modulo - ONE;
              tc          <= 1'b1;
              wrap_sticky <= 1'b1;
            end else if (!dir && (count == '0)) begin
              dir         <= 1'b1;
              count       <= ONE;
              tc          <= 1'b1;
              wrap_sticky <= 1'b1;
            end else if (dir) begin
              count <= count + ONE;
            end else begin
              count <= count - ONE;
            end
          end
          MODE_HOLD: begin
          end
        endcase
      end
    end
  end

endmodule
